gates_sweep_checker: RTL and testbench
======================================

// Module: gates_sweep_checker
// PURPOSE
//   Self-test driver/checker for the three-input two-output gate network (gates).
//   On start it drives all 8 input combinations, waits a settle interval, then samples
//   out1/out2 against a built-in golden model. It reports mismatch count, the first
//   failing vector and pass/fail. Used in board bring-up and as a BIST wrapper.
// PARAMETERS
//   SETTLE_CYCLES  2  cycles each vector is held before sampling; legal range >=1
//   PASSES         1  full 8-vector sweeps per start; legal range >=1
//   ERR_W          4  width of err_count; the count saturates at 2**ERR_W-1
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      request a sweep; sampled only in IDLE
//   busy         out  1      high while a sweep is in progress
//   done         out  1      one-cycle pulse when the sweep completes
//   drv_in1      out  1      driven to gate network in1 (= vec[0])
//   drv_in2      out  1      driven to gate network in2 (= vec[1])
//   drv_in3      out  1      driven to gate network in3 (= vec[2])
//   obs_out1     in   1      observed gate network out1
//   obs_out2     in   1      observed gate network out2
//   err_count    out  ERR_W  mismatching samples in the last/current sweep, saturating
//   first_err_vec out 3      vec of the first mismatch; valid when first_err_valid=1
//   first_err_valid out 1    set on first mismatch, cleared on start accept
//   pass         out  1      1 when the last completed sweep had err_count==0
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, all outputs 0, vec=0, pass_cnt=0.
//   - Golden model: exp1 = ((in1&in2)|~in2)&~in2 (reduces to ~in2); exp2 = ~(in1^in3).
//   - FSM states IDLE, DRIVE, SAMPLE, DONE:
//     IDLE: start=1 at an edge leads to DRIVE. On that edge vec=0, pass_cnt=0 and
//       settle_cnt=0. err_count, first_err_* and pass are cleared. busy becomes 1.
//     DRIVE: drv_in* = vec. settle_cnt increments. After SETTLE_CYCLES cycles in DRIVE,
//       go to SAMPLE.
//     SAMPLE: one cycle. Compare {obs_out2,obs_out1} with {exp2,exp1}(vec).
//       On mismatch: err_count+1 (saturating). If !first_err_valid, capture vec and
//       set first_err_valid. Next state:
//       - vec==7 and pass_cnt==PASSES-1: go to DONE.
//       - vec==7 otherwise: vec wraps to 0, pass_cnt+1, go to DRIVE.
//       - else: vec+1, go to DRIVE.
//     DONE: done=1 for exactly one cycle. busy=0. pass=(err_count==0). Go to IDLE.
//   - drv_in* hold vec during SAMPLE as well. They return to 0 in DONE and IDLE.
//   - Per vector: SETTLE_CYCLES+1 cycles. busy is high for 8*PASSES*(SETTLE_CYCLES+1)
//     cycles, then done pulses.
//   - start while busy or in DONE: ignored, no restart. Holding start high in IDLE
//     immediately re-arms the next sweep.
//   - err_count, first_err_* and pass hold their values after DONE until the next start
//     accept.
//   - rst_n low mid-sweep: everything returns at once to the reset values; no done pulse.
// STRUCTURE
//   - Shared include gates_defs.vh holds:
//     - state encodings (2-bit localparams);
//     - function gates_golden(input [2:0] v) returning {exp2,exp1};
//     - VEC_W=3 and NUM_VEC=8.
//   - One natural sub-module: gates_ref_model. It is a combinational golden model and the
//     bench reuses it.
//   - Top level: FSM, settle counter, vec/pass counters, error capture registers.
// TESTING
//   1 SETTLE=2,PASSES=1, real gates wired: start pulse -> busy 24 cyc, done pulse,
//     err_count=0, pass=1
//   2 obs_out1 tied 0 -> mismatches at vec 0,1,4,5: err_count=4, first_err_vec=3'b000,
//     pass=0
//   3 obs_out2 inverted, PASSES=3, ERR_W=4 -> 24 mismatches, err_count saturates at 15,
//     first_err_vec=0
//   4 start held high throughout -> no restart while busy; next sweep starts the cycle
//     after done, with counters cleared
//   5 rst_n low while vec=5 -> drv_in*=0, busy=0, err_count=0 immediately; later start
//     -> clean full sweep
//   6 drv sequence monitor -> {drv_in3,drv_in2,drv_in1} steps 0..7, each held exactly 3
//     cycles (SETTLE=2)

Source files
------------

// File: rtl/gates_sweep_checker_pkg.sv
// Shared definitions for the gate-network sweep checker: FSM encodings,
// vector geometry and the golden model of the three-input gate network.
package gates_sweep_checker_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Returns {exp2, exp1}; vec[0]=in1, vec[1]=in2, vec[2]=in3.
    function automatic logic [1:0] gates_golden(input logic [VEC_W-1:0] v);
        logic in1;
        logic in2;
        logic in3;
        logic exp1;
        logic exp2;
        in1  = v[0];
        in2  = v[1];
        in3  = v[2];
        exp1 = ((in1 & in2) | ~in2) & ~in2;
        exp2 = ~(in1 ^ in3);
        return {exp2, exp1};
    endfunction

endpackage

// File: rtl/gates_sweep_checker_ref_model.sv
// Combinational golden model of the gate network, evaluated for one input vector.
module gates_sweep_checker_ref_model
    import gates_sweep_checker_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp1,
    output logic             exp2
);

    assign {exp2, exp1} = gates_golden(vec);

endmodule

// File: rtl/gates_sweep_checker.sv
// Sweeps all eight input vectors into the gate network, holds each for a settle
// interval, then samples the network outputs against the golden model.
module gates_sweep_checker
    import gates_sweep_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             drv_in1,
    output logic             drv_in2,
    output logic             drv_in3,
    input  logic             obs_out1,
    input  logic             obs_out2,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid,
    output logic             pass,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a level request accepted only when the FSM sits in
    // IDLE at a rising edge; busy rises on that edge and done pulses one cycle
    // after the last sample. start seen in any other state is dropped.

    localparam int SET_W  = $clog2(SETTLE_CYCLES) + 1;
    localparam int PASS_W = $clog2(PASSES) + 1;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [VEC_W-1:0]   first_err_vec_q, first_err_vec_d;
    logic               first_err_valid_q, first_err_valid_d;
    logic               pass_q, pass_d;

    logic exp1;
    logic exp2;
    logic settle_last;
    logic vec_last;
    logic sweep_last;
    logic mismatch;

    gates_sweep_checker_ref_model u_ref (
        .vec  (vec_q),
        .exp1 (exp1),
        .exp2 (exp2)
    );

    assign settle_last = (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
    assign vec_last    = (vec_q == VEC_W'(NUM_VEC - 1));
    assign sweep_last  = vec_last && (pass_cnt_q == PASS_W'(PASSES - 1));
    assign mismatch    = ({obs_out2, obs_out1} != {exp2, exp1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            vec_q             <= '0;
            pass_cnt_q        <= '0;
            settle_cnt_q      <= '0;
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            pass_cnt_q        <= pass_cnt_d;
            settle_cnt_q      <= settle_cnt_d;
            err_count_q       <= err_count_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
            pass_q            <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  if (settle_last) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = sweep_last ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_d             = vec_q;
        pass_cnt_d        = pass_cnt_q;
        settle_cnt_d      = settle_cnt_q;
        err_count_d       = err_count_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        pass_d            = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d             = '0;
                    pass_cnt_d        = '0;
                    settle_cnt_d      = '0;
                    err_count_d       = '0;
                    first_err_vec_d   = '0;
                    first_err_valid_d = 1'b0;
                    pass_d            = 1'b0;
                end
            end
            ST_DRIVE: settle_cnt_d = settle_cnt_q + SET_W'(1);
            ST_SAMPLE: begin
                settle_cnt_d = '0;
                if (mismatch) begin
                    if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                    if (!first_err_valid_q) begin
                        first_err_vec_d   = vec_q;
                        first_err_valid_d = 1'b1;
                    end
                end
                // pass is settled on the edge into DONE so it is valid alongside done.
                if (sweep_last) begin
                    pass_d = (err_count_d == '0);
                end else if (vec_last) begin
                    vec_d      = '0;
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                end else begin
                    vec_d = vec_q + VEC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
        done    = (state_q == ST_DONE);
        drv_in1 = busy & vec_q[0];
        drv_in2 = busy & vec_q[1];
        drv_in3 = busy & vec_q[2];
    end

    assign err_count       = err_count_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;
    assign pass            = pass_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Directed bench for gates_sweep_checker: drives a modelled gate network with
// optional faults and checks sweep timing, error capture and reset behaviour.
module tb_gates_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start3;
    int         fault_mode;
    int         errors;
    int         checks;

    logic       busy, done, drv_in1, drv_in2, drv_in3, obs_out1, obs_out2;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    logic       first_err_valid, pass;
    logic [1:0] state_dbg;

    logic       busy3, done3, d3_in1, d3_in2, d3_in3, obs3_out1, obs3_out2;
    logic [3:0] err_count3;
    logic [2:0] first_err_vec3;
    logic       first_err_valid3, pass3;
    logic [1:0] state_dbg3;

    logic       net_out1, net_out2;
    logic [2:0] drv_log[$];
    logic [2:0] exp_q[$];

    // Gate network as built on the board, with fault injection for dut.
    assign net_out1 = ((drv_in1 & drv_in2) | ~drv_in2) & ~drv_in2;
    assign net_out2 = ~(drv_in1 ^ drv_in3);
    assign obs_out1 = (fault_mode == 1) ? 1'b0 : net_out1;
    assign obs_out2 = (fault_mode == 2) ? ~net_out2 : net_out2;
    assign obs3_out1 = ((d3_in1 & d3_in2) | ~d3_in2) & ~d3_in2;
    assign obs3_out2 = d3_in1 ^ d3_in3;

    gates_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
        .obs_out1(obs_out1), .obs_out2(obs_out2), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid),
        .pass(pass), .state_dbg(state_dbg)
    );

    gates_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .drv_in1(d3_in1), .drv_in2(d3_in2), .drv_in3(d3_in3),
        .obs_out1(obs3_out1), .obs_out2(obs3_out2), .err_count(err_count3),
        .first_err_vec(first_err_vec3), .first_err_valid(first_err_valid3),
        .pass(pass3), .state_dbg(state_dbg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a sweep on dut, then count busy samples until busy drops.
    task automatic run_sweep(input bit hold, output int busy_len, output logic done_seen);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        busy_len = 0;
        drv_log.delete();
        while (busy === 1'b1 && busy_len < 500) begin
            busy_len++;
            drv_log.push_back({drv_in3, drv_in2, drv_in1});
            tick();
        end
        done_seen = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        fault_mode = 0;
        #23;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({drv_in3, drv_in2, drv_in1} !== 3'b000) begin errors++; $display("FAIL reset_drv: got %b want 000", {drv_in3, drv_in2, drv_in1}); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
        checks++; if ({first_err_valid, first_err_vec, pass} !== 5'b0) begin errors++; $display("FAIL reset_capture: got %b want 00000", {first_err_valid, first_err_vec, pass}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        checks++; if ({busy3, done3, err_count3} !== 6'b0) begin errors++; $display("FAIL reset_dut3: got %b want 0", {busy3, done3, err_count3}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean_sweep();
        int len;
        logic dn;
        fault_mode = 0;
        run_sweep(1'b0, len, dn);
        checks++; if (len != 24) begin errors++; $display("FAIL clean_busy_len: got %0d want 24", len); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL clean_done: got %b want 1", dn); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", err_count); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b want 1", pass); end
        checks++; if (first_err_valid !== 1'b0) begin errors++; $display("FAIL clean_fev: got %b want 0", first_err_valid); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_width: got %b want 0", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass_hold: got %b want 1", pass); end
    endtask

    task automatic test_out1_stuck();
        int len;
        logic dn;
        fault_mode = 1;
        run_sweep(1'b0, len, dn);
        checks++; if (len != 24 || dn !== 1'b1) begin errors++; $display("FAIL stuck_timing: got len %0d done %b want 24 1", len, dn); end
        checks++; if (err_count !== 4'd4) begin errors++; $display("FAIL stuck_err: got %0d want 4", err_count); end
        checks++; if (first_err_vec !== 3'b000) begin errors++; $display("FAIL stuck_first_vec: got %b want 000", first_err_vec); end
        checks++; if (first_err_valid !== 1'b1) begin errors++; $display("FAIL stuck_fev: got %b want 1", first_err_valid); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b want 0", pass); end
        tick();
        fault_mode = 0;
    endtask

    task automatic test_saturation();
        int len;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        len = 0;
        while (busy3 === 1'b1 && len < 500) begin
            len++;
            tick();
        end
        checks++; if (len != 72) begin errors++; $display("FAIL sat_busy_len: got %0d want 72", len); end
        checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL sat_done: got %b want 1", done3); end
        checks++; if (err_count3 !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d want 15", err_count3); end
        checks++; if (first_err_vec3 !== 3'b000 || first_err_valid3 !== 1'b1) begin errors++; $display("FAIL sat_first: got %b/%b want 000/1", first_err_vec3, first_err_valid3); end
        checks++; if (pass3 !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b want 0", pass3); end
        tick();
    endtask

    task automatic test_start_held();
        int len;
        logic dn;
        fault_mode = 1;
        run_sweep(1'b1, len, dn);
        checks++; if (len != 24) begin errors++; $display("FAIL held_busy_len: got %0d want 24", len); end
        checks++; if (dn !== 1'b1 || err_count !== 4'd4) begin errors++; $display("FAIL held_done_err: got %b/%0d want 1/4", dn, err_count); end
        fault_mode = 0;
        tick();
        checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL held_idle: got busy %b state %0d want 0 0", busy, state_dbg); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_rearm: got %b want 1", busy); end
        checks++; if (err_count !== 4'd0 || first_err_valid !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL held_cleared: got %0d/%b/%b want 0/0/0", err_count, first_err_valid, pass); end
        start = 1'b0;
        len = 0;
        while (busy === 1'b1 && len < 500) begin
            len++;
            tick();
        end
        checks++; if (len != 24 || done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL held_second: got len %0d done %b pass %b want 24 1 1", len + 1, done, pass); end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int len;
        logic dn;
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ({drv_in3, drv_in2, drv_in1} !== 3'd5 && n < 200) begin
            n++;
            tick();
        end
        checks++; if ({drv_in3, drv_in2, drv_in1} !== 3'd5) begin errors++; $display("FAIL midrst_reach_vec5: got %0d want 5", {drv_in3, drv_in2, drv_in1}); end
        checks++; if (err_count !== 4'd3) begin errors++; $display("FAIL midrst_err_before: got %0d want 3", err_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({drv_in3, drv_in2, drv_in1} !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got drv %b busy %b want 000 0", {drv_in3, drv_in2, drv_in1}, busy); end
        checks++; if (err_count !== 4'd0 || first_err_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_state: got err %0d fev %b done %b want 0 0 0", err_count, first_err_valid, done); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got done %b busy %b want 0 0", done, busy); end
        fault_mode = 0;
        run_sweep(1'b0, len, dn);
        checks++; if (len != 24 || dn !== 1'b1 || err_count !== 4'd0 || pass !== 1'b1) begin errors++; $display("FAIL midrst_recover: got len %0d done %b err %0d pass %b want 24 1 0 1", len, dn, err_count, pass); end
        tick();
    endtask

    task automatic test_drv_sequence();
        int len;
        logic dn;
        logic [2:0] e;
        fault_mode = 0;
        exp_q.delete();
        for (int v = 0; v < 8; v++)
            for (int r = 0; r < 3; r++) exp_q.push_back(3'(v));
        run_sweep(1'b0, len, dn);
        checks++; if (drv_log.size() != exp_q.size()) begin errors++; $display("FAIL drvseq_len: got %0d want %0d", drv_log.size(), exp_q.size()); end
        for (int i = 0; i < 24; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i >= drv_log.size() || drv_log[i] !== e) begin
                errors++;
                $display("FAIL drvseq_step%0d: got %b want %b", i, (i < drv_log.size()) ? drv_log[i] : 3'bxxx, e);
            end
        end
        checks++; if ({drv_in3, drv_in2, drv_in1} !== 3'd0) begin errors++; $display("FAIL drvseq_done_drv: got %b want 000", {drv_in3, drv_in2, drv_in1}); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_clean_sweep();
        test_out1_stuck();
        test_saturation();
        test_start_held();
        test_reset_mid_sweep();
        test_drv_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
